// File: rtl/dsp_param_writer.sv
// ---------------------------------------------------------------------------
// dsp_param_writer
//
// Host-side write port for the DSP core's double-banked parameter RAM.
// A byte stream from the control CPU carries two packet types:
//   write  : 0x01, ADDR_HI, ADDR_LO, DATA_BYTES data bytes (MS byte first)
//   commit : 0x02
// Writes always land in the shadow bank (~active_bank). A commit waits for
// the next frame_start pulse and then swaps banks. This gives the core a
// coherent parameter set for a whole frame.
//
// Ports
//   clk            system clock (shared with the DSP core)
//   reset_n        synchronous active-low reset
//   in_data        host byte
//   in_valid       in_data is valid
//   in_ready       block accepts a byte this cycle
//   frame_start    one-cycle pulse at the start of each sample frame
//   param_wr_data  RAM write data (registered, held between writes)
//   param_wr_addr  RAM write address, MSB = shadow bank (registered, held)
//   param_wr_en    RAM write strobe, one cycle per write
//   active_bank    bank currently read by the core
//   commit_pending a commit is waiting for frame_start
//   err_count      unknown command bytes seen, saturating at 255
// ---------------------------------------------------------------------------
module dsp_param_writer #(
  parameter int PARAM_WIDTH      = 36,
  parameter int PARAM_ADDR_WIDTH = 10,
  parameter int DATA_BYTES       = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        frame_start,
  output logic [PARAM_WIDTH-1:0]      param_wr_data,
  output logic [PARAM_ADDR_WIDTH-1:0] param_wr_addr,
  output logic                        param_wr_en,
  output logic                        active_bank,
  output logic                        commit_pending,
  output logic [7:0]                  err_count
);

  localparam int ADDR_W  = PARAM_ADDR_WIDTH - 1;
  localparam int SHIFT_W = 8 * DATA_BYTES;
  localparam int CNT_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DATA_BYTES - 1);
  localparam logic [7:0]       CMD_WRITE  = 8'h01;
  localparam logic [7:0]       CMD_COMMIT = 8'h02;
  localparam logic [7:0]       ERR_MAX    = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_WRITE,
    S_COMMIT_WAIT
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [7:0]           addr_hi_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [SHIFT_W-1:0]   shift_d;
  logic [CNT_W-1:0]     cnt_q;

  logic accept;
  logic last_byte;
  logic bad_cmd;
  logic swap;

  // Ready depends only on state and reset, never on in_valid, so the host
  // can hold a byte on the bus across WRITE/COMMIT_WAIT without it being
  // consumed.
  assign in_ready = reset_n &&
                    (state_q inside {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA});
  assign accept   = in_valid && in_ready;

  assign last_byte = (state_q == S_DATA) && accept && (cnt_q == LAST_CNT);
  assign bad_cmd   = (state_q == S_IDLE) && accept &&
                     (in_data != CMD_WRITE) && (in_data != CMD_COMMIT);
  assign swap      = (state_q == S_COMMIT_WAIT) && frame_start;

  // Shift the new byte in at the bottom; the top byte falls off, so after
  // DATA_BYTES shifts the register holds the whole big-endian field.
  assign shift_d = SHIFT_W'({shift_q, in_data});

  assign commit_pending = (state_q == S_COMMIT_WAIT);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and process ordering cannot change behaviour.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_data == CMD_WRITE)       state_d = S_ADDR_HI;
          else if (in_data == CMD_COMMIT) state_d = S_COMMIT_WAIT;
        end
      end
      S_ADDR_HI:     if (accept)    state_d = S_ADDR_LO;
      S_ADDR_LO:     if (accept)    state_d = S_DATA;
      S_DATA:        if (last_byte) state_d = S_WRITE;
      S_WRITE:                      state_d = S_IDLE;
      // A frame_start coincident with the commit byte arrives while still
      // in IDLE and is ignored; only a pulse seen here completes the swap.
      S_COMMIT_WAIT: if (frame_start) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: packet assembly, registered write port, bank and error count
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_hi_q     <= '0;
      addr_q        <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      param_wr_en   <= 1'b0;
      param_wr_addr <= '0;
      param_wr_data <= '0;
      active_bank   <= 1'b0;
      err_count     <= '0;
    end else begin
      // Strobe is high only in the WRITE cycle that follows the last byte.
      param_wr_en <= last_byte;

      if ((state_q == S_ADDR_HI) && accept) addr_hi_q <= in_data;

      if ((state_q == S_ADDR_LO) && accept) begin
        // Upper address bits beyond the host-visible width are dropped.
        addr_q <= ADDR_W'({addr_hi_q, in_data});
        cnt_q  <= '0;
      end

      if ((state_q == S_DATA) && accept) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_q + CNT_W'(1);
      end

      // Address and data are captured together with the strobe and then
      // held until the next write. The bank bit always selects the shadow.
      if (last_byte) begin
        param_wr_addr <= {~active_bank, addr_q};
        param_wr_data <= PARAM_WIDTH'(shift_d);
      end

      // Swaps happen only in COMMIT_WAIT and writes only leave DATA, so a
      // write and a swap can never share a cycle.
      if (swap) active_bank <= ~active_bank;

      if (bad_cmd && (err_count != ERR_MAX)) err_count <= err_count + 8'd1;
    end
  end

endmodule
